// File: rtl/seq_array_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, optional
// two's-complement mode via sign/magnitude, valid/ready on both sides.
module seq_array_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;    // {partial sum, remaining multiplier bits}
  logic [CNT_W-1:0]     cnt;
  logic                 neg;
  logic                 mode_q;
  logic                 accept;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       sum;

  assign accept = in_valid && in_ready;

  // Signed operands are reduced to magnitudes; the most negative value maps
  // to 2^(WIDTH-1), which still fits the unsigned WIDTH-bit field.
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (signed_mode && a[WIDTH-1]) a_mag = ~a + WIDTH'(1);
    if (signed_mode && b[WIDTH-1]) b_mag = ~b + WIDTH'(1);
  end

  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0]) sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)    state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    if (out_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      mode_q  <= 1'b0;
      product <= '0;
    end else if (accept) begin
      mode_q <= signed_mode;
      neg    <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
      mcand  <= a_mag;
      acc    <= {{WIDTH{1'b0}}, b_mag};
      cnt    <= '0;
    end else if (state == RUN) begin
      if (cnt != LAST) begin
        acc <= {sum, acc[WIDTH-1:1]};
        cnt <= cnt + CNT_W'(1);
      end else begin
        product <= (mode_q && neg) ? (~acc + (2*WIDTH)'(1)) : acc;
      end
    end
  end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed and randomised checks of seq_array_multiplier at WIDTH=8 and WIDTH=4.
module tb_seq_array_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv8 = 0, ir8, sm8 = 0, ov8, or8 = 0, busy8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] p8;
  logic        iv4 = 0, ir4, sm4 = 0, ov4, or4 = 0, busy4;
  logic [3:0]  a4 = 0, b4 = 0;
  logic [7:0]  p4;

  int n_chk = 0;
  int n_fail = 0;

  seq_array_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8));

  seq_array_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .signed_mode(sm4), .out_valid(ov4), .out_ready(or4), .product(p4), .busy(busy4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one WIDTH=8 op, check latency/result, optionally stall before the take.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic sm,
                     input logic [15:0] exp, input int stall, input string tag);
    int n;
    @(negedge clk);
    a8 = ta; b8 = tb; sm8 = sm; iv8 = 1'b1; or8 = (stall == 0);
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = ~ta; b8 = ~tb; sm8 = ~sm;
    n = 0;
    while (!ov8 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check($sformatf("%s lat", tag), n, 9);
    check($sformatf("%s prod", tag), p8, exp);
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1;
      check($sformatf("%s hold", tag), {ov8, p8}, {1'b1, exp});
      or8 = 1'b1;
    end
    @(posedge clk); #1;
    check($sformatf("%s take", tag), {ov8, ir8, busy8}, 3'b010);
    or8 = 1'b0;
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic sm,
                     input logic [7:0] exp, input string tag);
    int n;
    @(negedge clk);
    a4 = ta; b4 = tb; sm4 = sm; iv4 = 1'b1; or4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    n = 0;
    while (!ov4 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check($sformatf("%s lat", tag), n, 5);
    check($sformatf("%s prod", tag), p4, exp);
    @(posedge clk); #1;
    check($sformatf("%s take", tag), {ov4, ir4}, 2'b01);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rs;
    int         sa, sb, saw;

    #12;
    check("rst8", {p8, ir8, ov8, busy8}, {16'h0, 3'b100});
    check("rst4", {p4, ir4, ov4, busy4}, {8'h0, 3'b100});
    @(negedge clk) rst_n = 1'b1;

    op4(4'hF, 4'hF, 1'b0, 8'hE1, "w4 15x15");
    op8(8'h80, 8'h80, 1'b1, 16'h4000, 0, "s min*min");
    op8(8'hFD, 8'h05, 1'b1, 16'hFFF1, 0, "s -3*5");
    op8(8'h7F, 8'h81, 1'b1, 16'hC0FF, 0, "s 127*-127");
    op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, "u ff*ff");
    op8(8'hFF, 8'hFF, 1'b1, 16'h0001, 0, "s -1*-1");
    op8(8'h00, 8'hA5, 1'b0, 16'h0000, 0, "u zero");
    op8(8'h01, 8'h80, 1'b1, 16'hFF80, 3, "s 1*-128");

    // Backpressure: hold for 20 cycles, in_valid pulses must be ignored.
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd5; sm8 = 1'b0; iv8 = 1'b1; or8 = 1'b0;
    @(posedge clk); #1 iv8 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin a8 = 8'd9; b8 = 8'd9; iv8 = 1'b1; end
      if (i == 6) iv8 = 1'b0;
      if (!ov8 || p8 !== 16'd15 || ir8) saw++;
      @(posedge clk); #1;
    end
    check("bp stall stable", saw, 0);
    check("bp still valid", {ov8, ir8, p8}, {2'b10, 16'd15});
    or8 = 1'b1;
    @(posedge clk); #1 or8 = 1'b0;
    check("bp take", {ov8, ir8, p8}, {2'b01, 16'd15});
    repeat (12) @(posedge clk);
    #1;
    check("bp no 2nd result", {ov8, busy8, p8}, {2'b00, 16'd15});

    // Reset in the middle of RUN.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd200; sm8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
    @(posedge clk); #1 iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("mid rst", {p8, ir8, ov8, busy8}, {16'h0, 3'b100});
    @(negedge clk) rst_n = 1'b1;
    saw = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ov8) saw++;
    end
    check("mid rst no pulse", saw, 0);
    op8(8'd6, 8'd7, 1'b0, 16'd42, 0, "post rst 6*7");

    // WIDTH=4 exhaustive in both modes.
    saw = 0;
    for (int i = 0; i < 512; i++) begin
      rs = i[8];
      sa = rs ? int'($signed(i[3:0])) : int'(i[3:0]);
      sb = rs ? int'($signed(i[7:4])) : int'(i[7:4]);
      op4(i[3:0], i[7:4], rs, 8'(sa * sb), $sformatf("w4 #%0d", i));
    end

    // WIDTH=8 random with random stalls.
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      sa = rs ? int'($signed(ra)) : int'(ra);
      sb = rs ? int'($signed(rb)) : int'(rb);
      op8(ra, rb, rs, 16'(sa * sb), int'($urandom_range(0, 4)), $sformatf("rnd8 #%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
